// File: rtl/sobel_pkg.sv
// Shared types and lane helpers for the Sobel edge packer.
// Three 8-bit magnitude lanes live above an always-zero low byte in each 32-bit word.
package sobel_pkg;

  localparam int DATAWIDTH   = 32;
  localparam int MEMORYWIDTH = 8;
  localparam int PIXEL       = 3;
  localparam int LANE_BASE   = MEMORYWIDTH;
  localparam int LANE_STRIDE = MEMORYWIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic [MEMORYWIDTH-1:0] lane_extract(
    input logic [DATAWIDTH-1:0] data,
    input int                   lane
  );
    return data[LANE_BASE + lane*LANE_STRIDE +: MEMORYWIDTH];
  endfunction

  // pass=0 gives a binary edge map, pass=1 keeps the magnitude of edge pixels.
  function automatic logic [MEMORYWIDTH-1:0] lane_threshold(
    input logic [MEMORYWIDTH-1:0] mag,
    input logic [MEMORYWIDTH-1:0] thr,
    input logic                   pass
  );
    if (mag < thr) return '0;
    return pass ? mag : '1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One output register plus one skid entry, with a registered input ready.
// 'block' lets the owner close the input side without losing buffered beats.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             ARESET,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             block,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             skid_valid_d;
  logic             in_fire;
  logic             out_load;

  assign in_fire  = s_valid && s_ready;
  assign out_load = !m_valid || m_ready;

  // Ready never rises while the skid holds a beat, so a load of the output
  // register can never coincide with a new beat landing in the skid.
  always_comb begin
    skid_valid_d = skid_valid;
    if (out_load)     skid_valid_d = 1'b0;
    else if (in_fire) skid_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      // NOTE: payload registers are reset too, so the stream data reads 0 in reset.
      skid_data  <= '0;
      skid_valid <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      skid_valid <= skid_valid_d;
      s_ready    <= !skid_valid_d && !block;
      if (out_load) begin
        if (skid_valid) begin
          m_data  <= skid_data;
          m_valid <= 1'b1;
        end else if (in_fire) begin
          m_data  <= s_data;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/sobel_edge_packer.sv
// Thresholds Sobel magnitudes per row, repacks them for the S2MM stream and
// publishes per-row edge statistics, a row/frame counter and status LEDs.
module sobel_edge_packer
  import sobel_pkg::*;
#(
  parameter int CNTWIDTH       = 16,
  parameter int ROWS_PER_FRAME = 480
) (
  input  logic                   clk,
  input  logic                   ARESET,
  input  logic [DATAWIDTH-1:0]   S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [DATAWIDTH-1:0]   M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  input  logic [MEMORYWIDTH-1:0] THRESHOLD,
  input  logic                   MODE,
  output logic [CNTWIDTH-1:0]    ROW_EDGE_COUNT,
  output logic [CNTWIDTH-1:0]    ROW_BEATS,
  output logic                   ROW_DONE,
  output logic [CNTWIDTH-1:0]    ROW_INDEX,
  output logic                   FRAME_DONE,
  output logic [3:0]             LED
);

  localparam int                  INC_W    = $clog2(PIXEL + 1);
  localparam logic [CNTWIDTH-1:0] LAST_ROW = CNTWIDTH'(ROWS_PER_FRAME - 1);

  state_e                 state, state_d;
  logic                   s_fire, m_last_fire;
  logic [MEMORYWIDTH-1:0] thr_q, thr_eff, lane_m;
  logic                   mode_q, mode_eff;
  logic [DATAWIDTH-1:0]   pix_data;
  logic [INC_W-1:0]       edge_inc;
  logic [CNTWIDTH-1:0]    edge_run, beat_run;
  logic [CNTWIDTH:0]      edge_sum, beat_sum;
  logic                   sat_flag, frame_led;
  logic [DATAWIDTH:0]     m_payload;

  assign s_fire      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_last_fire = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

  // The first beat of a row is seen in IDLE and must already use the live settings.
  assign thr_eff  = (state == IDLE) ? THRESHOLD : thr_q;
  assign mode_eff = (state == IDLE) ? MODE      : mode_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    pix_data = '0;
    edge_inc = '0;
    lane_m   = '0;
    for (int j = 0; j < PIXEL; j++) begin
      lane_m = lane_extract(S_AXIS_TDATA, j);
      pix_data[LANE_BASE + j*LANE_STRIDE +: MEMORYWIDTH] = lane_threshold(lane_m, thr_eff, mode_eff);
      edge_inc = edge_inc + INC_W'(lane_m >= thr_eff);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (s_fire) state_d = S_AXIS_TLAST ? HOLD : ROW;
      ROW:     if (s_fire && S_AXIS_TLAST) state_d = HOLD;
      HOLD:    if (m_last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  axis_skid_buffer #(
    .WIDTH (DATAWIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .ARESET  (ARESET),
    .s_data  ({pix_data, S_AXIS_TLAST}),
    .s_valid (S_AXIS_TVALID),
    .s_ready (S_AXIS_TREADY),
    .block   (state_d == HOLD),
    .m_data  (m_payload),
    .m_valid (M_AXIS_TVALID),
    .m_ready (M_AXIS_TREADY)
  );

  assign M_AXIS_TDATA = m_payload[DATAWIDTH:1];
  assign M_AXIS_TLAST = m_payload[0];

  assign edge_sum = {1'b0, edge_run} + (CNTWIDTH+1)'(edge_inc);
  assign beat_sum = {1'b0, beat_run} + (CNTWIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (ARESET) begin
      state          <= IDLE;
      thr_q          <= '0;
      mode_q         <= 1'b0;
      edge_run       <= '0;
      beat_run       <= '0;
      ROW_EDGE_COUNT <= '0;
      ROW_BEATS      <= '0;
      ROW_INDEX      <= '0;
      ROW_DONE       <= 1'b0;
      FRAME_DONE     <= 1'b0;
      sat_flag       <= 1'b0;
      frame_led      <= 1'b0;
    end else begin
      state      <= state_d;
      ROW_DONE   <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (s_fire && state == IDLE) begin
        thr_q  <= THRESHOLD;
        mode_q <= MODE;
      end
      // Input is closed in HOLD, so row close-out and beat counting never overlap.
      if (m_last_fire) begin
        ROW_EDGE_COUNT <= edge_run;
        ROW_BEATS      <= beat_run;
        edge_run       <= '0;
        beat_run       <= '0;
        ROW_DONE       <= 1'b1;
        if (ROW_INDEX == LAST_ROW) begin
          ROW_INDEX  <= '0;
          FRAME_DONE <= 1'b1;
          frame_led  <= !frame_led;
        end else begin
          ROW_INDEX <= ROW_INDEX + 1'b1;
        end
      end else if (s_fire) begin
        edge_run <= edge_sum[CNTWIDTH] ? '1 : edge_sum[CNTWIDTH-1:0];
        beat_run <= beat_sum[CNTWIDTH] ? '1 : beat_sum[CNTWIDTH-1:0];
        if (edge_sum[CNTWIDTH] || beat_sum[CNTWIDTH]) sat_flag <= 1'b1;
      end
    end
  end

  assign LED = {sat_flag, frame_led, state == HOLD, state == ROW};

endmodule

// File: tb/tb_sobel_edge_packer.sv
// Directed bench for sobel_edge_packer: thresholding, stall buffering,
// threshold latching, frame wrap and mid-row reset, with hand-derived expectations.
module tb_sobel_edge_packer;

  logic        clk = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [7:0]  THRESHOLD = '0;
  logic        MODE = 1'b0;
  logic [15:0] ROW_EDGE_COUNT, ROW_BEATS, ROW_INDEX;
  logic        ROW_DONE, FRAME_DONE;
  logic [3:0]  LED;

  int checks = 0;
  int errors = 0;
  int row_done_cnt = 0;
  int frame_done_cnt = 0;
  int frame_misaligned = 0;
  int s_acc_cnt = 0;
  logic [32:0] out_q[$];

  // Lanes (lane2, lane1, lane0) = (200, 100, 99) and (200, 10, 9).
  localparam logic [31:0] W1 = 32'hC8646300;
  localparam logic [31:0] W4 = 32'hC80A0900;

  sobel_edge_packer #(
    .CNTWIDTH       (16),
    .ROWS_PER_FRAME (4)
  ) dut (
    .clk            (clk),
    .ARESET         (ARESET),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .THRESHOLD      (THRESHOLD),
    .MODE           (MODE),
    .ROW_EDGE_COUNT (ROW_EDGE_COUNT),
    .ROW_BEATS      (ROW_BEATS),
    .ROW_DONE       (ROW_DONE),
    .ROW_INDEX      (ROW_INDEX),
    .FRAME_DONE     (FRAME_DONE),
    .LED            (LED)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge; the negedge view shows what the next edge will transfer.
  always @(negedge clk) begin
    if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
    if (S_AXIS_TVALID && S_AXIS_TREADY) s_acc_cnt++;
    if (ROW_DONE) row_done_cnt++;
    if (FRAME_DONE) frame_done_cnt++;
    if (FRAME_DONE && !ROW_DONE) frame_misaligned++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    @(negedge clk);
    while (!S_AXIS_TREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 40'(n >= 100), 40'd0);
    @(posedge clk); #1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic wait_rows(input int n);
    int k = 0;
    while (row_done_cnt < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("row_done_timeout", 40'(k >= 200), 40'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string tag, input int n, input logic [31:0] data);
    check({tag, "_count"}, 40'(out_q.size()), 40'(n));
    for (int i = 0; i < n && i < out_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 40'(out_q[i]), 40'({i == n - 1, data}));
    out_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 40'(S_AXIS_TREADY), 40'd0);
    check("rst_m_valid", 40'(M_AXIS_TVALID), 40'd0);
    check("rst_m_data", 40'(M_AXIS_TDATA), 40'd0);
    check("rst_led", 40'(LED), 40'd0);
    check("rst_row_index", 40'(ROW_INDEX), 40'd0);
    @(posedge clk); #1;
    ARESET = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", 40'(S_AXIS_TREADY), 40'd1);

    // 1: T=100 binary mode, 4-word row, continuous ready
    M_AXIS_TREADY = 1'b1;
    THRESHOLD = 8'd100;
    MODE = 1'b0;
    send_beat(W1, 1'b0);
    check("t1_led_row", 40'(LED), 40'b0001);
    check("t1_latency_valid", 40'(M_AXIS_TVALID), 40'd1);
    check("t1_latency_data", 40'(M_AXIS_TDATA), 40'h00FFFF0000);
    send_beat(W1, 1'b0);
    send_beat(W1, 1'b0);
    send_beat(W1, 1'b1);
    wait_rows(1);
    check_out("t1", 4, 32'hFFFF0000);
    check("t1_edge_count", 40'(ROW_EDGE_COUNT), 40'd8);
    check("t1_beats", 40'(ROW_BEATS), 40'd4);
    check("t1_row_index", 40'(ROW_INDEX), 40'd1);

    // 2: pass-through mode, 1-word row
    repeat (3) @(posedge clk);
    #1;
    check("t1_single_row_done", 40'(row_done_cnt), 40'd1);
    THRESHOLD = 8'd50;
    MODE = 1'b1;
    send_beat(32'hFF323100, 1'b1);
    check("t2_led_hold", 40'(LED), 40'b0010);
    check("t2_s_ready_blocked", 40'(S_AXIS_TREADY), 40'd0);
    check("t2_out_data", 40'(M_AXIS_TDATA), 40'h00FF320000);
    check("t2_out_last", 40'(M_AXIS_TLAST), 40'd1);
    wait_rows(2);
    check_out("t2", 1, 32'hFF320000);
    check("t2_led_idle", 40'(LED), 40'd0);
    check("t2_beats", 40'(ROW_BEATS), 40'd1);
    check("t2_edge_count", 40'(ROW_EDGE_COUNT), 40'd2);

    // 3: 10-cycle downstream stall during a 6-word row, T=0 pass-through
    THRESHOLD = 8'd0;
    MODE = 1'b1;
    M_AXIS_TREADY = 1'b0;
    fork
      begin : drive_proc
        for (int i = 0; i < 6; i++)
          send_beat(32'h102030AA + 32'(i) * 32'h01010100, i == 5);
      end
      begin : stall_proc
        int base;
        int unstable;
        logic have;
        logic [32:0] held;
        base = s_acc_cnt;
        unstable = 0;
        have = 1'b0;
        held = '0;
        repeat (10) begin
          @(negedge clk);
          if (M_AXIS_TVALID) begin
            if (!have) begin
              held = {M_AXIS_TLAST, M_AXIS_TDATA};
              have = 1'b1;
            end else if ({M_AXIS_TLAST, M_AXIS_TDATA} !== held) begin
              unstable++;
            end
          end
        end
        check("t3_accepted_while_stalled", 40'(s_acc_cnt - base), 40'd2);
        check("t3_s_ready_low", 40'(S_AXIS_TREADY), 40'd0);
        check("t3_stall_stable", 40'(unstable), 40'd0);
        check("t3_held_word", 40'(held), 40'h0010203000);
        @(posedge clk); #1;
        M_AXIS_TREADY = 1'b1;
      end
    join
    wait_rows(3);
    check("t3_count", 40'(out_q.size()), 40'd6);
    for (int i = 0; i < 6 && i < out_q.size(); i++)
      check($sformatf("t3_word%0d", i), 40'(out_q[i]),
            40'({i == 5, (32'h102030AA + 32'(i) * 32'h01010100) & 32'hFFFFFF00}));
    out_q.delete();
    check("t3_beats", 40'(ROW_BEATS), 40'd6);
    check("t3_edge_count", 40'(ROW_EDGE_COUNT), 40'd18);
    check("t3_row_index", 40'(ROW_INDEX), 40'd3);

    // 4 + 5: threshold change mid-row; this row is the 4th, so the frame wraps
    THRESHOLD = 8'd100;
    MODE = 1'b0;
    send_beat(W4, 1'b0);
    send_beat(W4, 1'b0);
    THRESHOLD = 8'd10;
    send_beat(W4, 1'b0);
    send_beat(W4, 1'b1);
    wait_rows(4);
    check_out("t4_old_thr", 4, 32'hFF000000);
    check("t4_edge_count", 40'(ROW_EDGE_COUNT), 40'd4);
    check("t5_row_index_wrap", 40'(ROW_INDEX), 40'd0);
    check("t5_frame_done_cnt", 40'(frame_done_cnt), 40'd1);
    check("t5_led_frame", 40'(LED), 40'b0100);
    send_beat(W4, 1'b0);
    send_beat(W4, 1'b1);
    wait_rows(5);
    check_out("t4_new_thr", 2, 32'hFFFF0000);
    check("t4_new_edge_count", 40'(ROW_EDGE_COUNT), 40'd4);
    check("t4_new_beats", 40'(ROW_BEATS), 40'd2);
    check("t5_row_index_after", 40'(ROW_INDEX), 40'd1);
    check("t5_frame_done_once", 40'(frame_done_cnt), 40'd1);
    check("t5_led_toggled_once", 40'(LED), 40'b0100);
    check("t5_frame_with_row", 40'(frame_misaligned), 40'd0);

    // 6: reset with two beats buffered mid-row
    M_AXIS_TREADY = 1'b0;
    THRESHOLD = 8'd0;
    MODE = 1'b1;
    send_beat(32'h11223344, 1'b0);
    send_beat(32'h55667788, 1'b0);
    check("t6_two_buffered", 40'(S_AXIS_TREADY), 40'd0);
    ARESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_s_ready", 40'(S_AXIS_TREADY), 40'd0);
    check("t6_rst_m_valid", 40'(M_AXIS_TVALID), 40'd0);
    check("t6_rst_m_data", 40'(M_AXIS_TDATA), 40'd0);
    check("t6_rst_m_last", 40'(M_AXIS_TLAST), 40'd0);
    check("t6_rst_counters", 40'({ROW_EDGE_COUNT, ROW_BEATS}), 40'd0);
    check("t6_rst_row_index", 40'(ROW_INDEX), 40'd0);
    check("t6_rst_pulses", 40'({ROW_DONE, FRAME_DONE}), 40'd0);
    check("t6_rst_led", 40'(LED), 40'd0);
    @(posedge clk); #1;
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b1;
    out_q.delete();
    THRESHOLD = 8'd100;
    MODE = 1'b0;
    send_beat(W1, 1'b0);
    send_beat(W1, 1'b1);
    wait_rows(6);
    check_out("t6_new_row", 2, 32'hFFFF0000);
    check("t6_beats", 40'(ROW_BEATS), 40'd2);
    check("t6_edge_count", 40'(ROW_EDGE_COUNT), 40'd4);
    check("t6_row_index", 40'(ROW_INDEX), 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
